// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM encoding, memory limits and command types for the data-memory arbiter
package dmem_arb_pkg;
  localparam int          MEM_BYTES  = 256;
  localparam logic [15:0] ADDR_LIMIT = 16'h00FF;
  localparam logic        CMD_LD     = 1'b0;
  localparam logic        CMD_ST     = 1'b1;
  typedef enum logic {S_IDLE, S_ISSUE} state_t;
  // A 16-bit access touches addr and addr+1, so the last byte cannot start a word.
  function automatic logic addr_err(input logic [15:0] addr);
    return (addr >= 16'(MEM_BYTES)) || (addr == ADDR_LIMIT);
  endfunction
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: load/store arbiter in front of a 256-byte data memory, store-priority with load anti-starvation
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int TAG_W      = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [15:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_rsp_valid,
  output logic [15:0]      ld_rsp_data,
  output logic [TAG_W-1:0] ld_rsp_tag,
  output logic             ld_rsp_err,
  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [15:0]      st_addr,
  input  logic [15:0]      st_data,
  output logic             st_rsp_valid,
  output logic             st_rsp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata
);
  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             issue, ld_win, hs;
  logic             cmd_type, cmd_err;
  logic [15:0]      cmd_addr, cmd_data;
  logic [TAG_W-1:0] cmd_tag;
  logic             pend_ld, pend_st, pend_err;
  logic [TAG_W-1:0] pend_tag;
  always_comb begin
    issue        = state == S_ISSUE;
    ld_win       = ld_req_valid && (!st_req_valid || starve_cnt == CNT_MAX);
    ld_req_ready = rst_n && !issue && ld_win;
    st_req_ready = rst_n && !issue && st_req_valid && !ld_win;
    hs           = ld_req_ready || st_req_ready;
    state_nxt    = (!issue && hs) ? S_ISSUE : S_IDLE;
    starve_nxt   = issue ? starve_cnt :
                   (ld_req_ready || !ld_req_valid) ? '0 :
                   (st_req_ready && starve_cnt != CNT_MAX) ? starve_cnt + 1'b1 : starve_cnt;
    mem_read     = issue && cmd_type == CMD_LD && !cmd_err;
    mem_write    = issue && cmd_type == CMD_ST && !cmd_err;
    mem_addr     = issue ? cmd_addr : '0;
    mem_wdata    = (issue && cmd_type == CMD_ST) ? cmd_data : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_type <= CMD_LD;
      cmd_err  <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_tag  <= '0;
    end else if (hs) begin
      cmd_type <= st_req_ready ? CMD_ST : CMD_LD;
      cmd_addr <= st_req_ready ? st_addr : ld_addr;
      cmd_err  <= addr_err(st_req_ready ? st_addr : ld_addr);
      cmd_data <= st_data;
      cmd_tag  <= ld_tag;
    end
  end
  // Memory answers on the ISSUE negedge; one extra stage aligns the response with the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ld      <= 1'b0;
      pend_st      <= 1'b0;
      pend_err     <= 1'b0;
      pend_tag     <= '0;
      ld_rsp_valid <= 1'b0;
      ld_rsp_err   <= 1'b0;
      ld_rsp_data  <= '0;
      ld_rsp_tag   <= '0;
      st_rsp_valid <= 1'b0;
      st_rsp_err   <= 1'b0;
    end else begin
      pend_ld      <= issue && cmd_type == CMD_LD;
      pend_st      <= issue && cmd_type == CMD_ST;
      pend_err     <= issue && cmd_err;
      pend_tag     <= issue ? cmd_tag : pend_tag;
      ld_rsp_valid <= pend_ld;
      ld_rsp_err   <= pend_ld && pend_err;
      st_rsp_valid <= pend_st;
      st_rsp_err   <= pend_st && pend_err;
      if (pend_ld) begin
        ld_rsp_data <= pend_err ? '0 : mem_rdata;
        ld_rsp_tag  <= pend_tag;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int TAG_W = 3;
  localparam int STARVE_MAX = 4;
  logic clk = 0, rst_n = 0;
  logic ld_req_valid = 0, st_req_valid = 0;
  logic [15:0] ld_addr = 0, st_addr = 0, st_data = 0;
  logic [TAG_W-1:0] ld_tag = 0;
  logic ld_req_ready, st_req_ready, ld_rsp_valid, ld_rsp_err, st_rsp_valid, st_rsp_err;
  logic [15:0] ld_rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic [TAG_W-1:0] ld_rsp_tag;
  logic mem_read, mem_write;
  int cyc = 0, n_chk = 0, n_pass = 0;
  logic [7:0] dmem [256];
  logic [7:0] ref_mem [256];
  bit mem_loaded = 0;

  dmem_arbiter #(.TAG_W(TAG_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_tag(ld_rsp_tag), .ld_rsp_err(ld_rsp_err),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_addr(st_addr), .st_data(st_data),
    .st_rsp_valid(st_rsp_valid), .st_rsp_err(st_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      100: return 8'h9C; 101: return 8'h40;
      102: return 8'h75; 103: return 8'h30;
      120: return 8'hAA; 121: return 8'hAA;
      122: return 8'h55; 123: return 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  // 256-byte data memory: big-endian word, registered on negedge
  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_byte(i);
      mem_loaded <= 1;
    end else begin
      if (mem_write) begin
        dmem[mem_addr[7:0]] <= mem_wdata[15:8];
        dmem[mem_addr[7:0] + 8'd1] <= mem_wdata[7:0];
      end
      if (mem_read) mem_rdata <= {dmem[mem_addr[7:0]], dmem[mem_addr[7:0] + 8'd1]};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_err(input logic [15:0] a);
    return a >= 16'h00FF;
  endfunction

  typedef struct {
    int due; bit is_ld; bit err;
    logic [15:0] addr; logic [15:0] data; logic [TAG_W-1:0] tag;
  } txn_t;
  txn_t rsp_q[$];
  txn_t cur;
  int cmd_cyc = -10, last_n = -10, starve = 0;
  logic [15:0] last_data = 0;
  logic [TAG_W-1:0] last_tag = 0;
  bit grants[$];

  task automatic mon_step();
    txn_t t;
    bit exp_lv, exp_sv, can, exp_lr, exp_sr, exp_rd, exp_wr;
    logic [7:0] a;
    t = '{default: 0};
    if (!rst_n) begin
      check("reset_outputs", {ld_req_ready, st_req_ready, ld_rsp_valid, st_rsp_valid, ld_rsp_err, st_rsp_err,
            mem_read, mem_write, mem_addr, mem_wdata, ld_rsp_data, ld_rsp_tag}, '0);
      rsp_q.delete();
      cmd_cyc = -10; last_n = -10; starve = 0; last_data = 0; last_tag = 0;
      return;
    end
    exp_lv = 0; exp_sv = 0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      t = rsp_q.pop_front();
      exp_lv = t.is_ld; exp_sv = !t.is_ld;
    end
    a = t.addr[7:0];
    if (exp_lv) begin
      last_data = t.err ? 16'h0 : {ref_mem[a], ref_mem[a + 8'd1]};
      last_tag = t.tag;
    end
    if (exp_sv && !t.err) begin
      ref_mem[a] = t.data[15:8];
      ref_mem[a + 8'd1] = t.data[7:0];
    end
    check("ld_rsp_valid", ld_rsp_valid, exp_lv);
    check("st_rsp_valid", st_rsp_valid, exp_sv);
    check("ld_rsp_err", ld_rsp_err, exp_lv & t.err);
    check("st_rsp_err", st_rsp_err, exp_sv & t.err);
    check("ld_rsp_data", ld_rsp_data, last_data);
    check("ld_rsp_tag", ld_rsp_tag, last_tag);
    exp_rd = cmd_cyc == cyc && cur.is_ld && !cur.err;
    exp_wr = cmd_cyc == cyc && !cur.is_ld && !cur.err;
    check("mem_read", mem_read, exp_rd);
    check("mem_write", mem_write, exp_wr);
    check("mem_addr", mem_addr, cmd_cyc == cyc ? cur.addr : 16'h0);
    if (cmd_cyc != cyc) check("mem_wdata_idle", mem_wdata, 0);
    else if (exp_wr) check("mem_wdata", mem_wdata, cur.data);
    can = cyc + 1 >= last_n + 2;
    exp_lr = can && ld_req_valid && (!st_req_valid || starve >= STARVE_MAX);
    exp_sr = can && st_req_valid && !exp_lr;
    check("ld_req_ready", ld_req_ready, exp_lr);
    check("st_req_ready", st_req_ready, exp_sr);
    if (can && !ld_req_valid) starve = 0;
    if (exp_lr || exp_sr) begin
      cur.is_ld = exp_lr;
      cur.addr = exp_lr ? ld_addr : st_addr;
      cur.data = st_data;
      cur.tag = ld_tag;
      cur.err = is_err(cur.addr);
      cur.due = cyc + 3;
      rsp_q.push_back(cur);
      cmd_cyc = cyc + 1;
      last_n = cyc + 1;
      grants.push_back(exp_lr);
      if (exp_lr) starve = 0;
      else if (ld_req_valid && starve < STARVE_MAX) starve++;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input bit is_ld);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = is_ld ? ld_req_ready : st_req_ready;
      tick();
    end
    check(is_ld ? "ld_accept_timeout" : "st_accept_timeout", ok, 1);
  endtask

  task automatic do_ld(input logic [15:0] a, input logic [TAG_W-1:0] tg);
    ld_req_valid = 1; ld_addr = a; ld_tag = tg;
    wait_acc(1);
    ld_req_valid = 0;
  endtask

  task automatic do_st(input logic [15:0] a, input logic [15:0] d);
    st_req_valid = 1; st_addr = a; st_data = d;
    wait_acc(0);
    st_req_valid = 0;
  endtask

  task automatic get_ld(output logic [15:0] d, output logic [TAG_W-1:0] tg, output logic e);
    bit ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      ok = ld_rsp_valid;
    end
    check("ld_rsp_timeout", ok, 1);
    d = ld_rsp_data; tg = ld_rsp_tag; e = ld_rsp_err;
    tick();
  endtask

  task automatic get_st(output logic e);
    bit ok = 0;
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      ok = st_rsp_valid;
    end
    check("st_rsp_timeout", ok, 1);
    e = st_rsp_err;
    tick();
  endtask

  task automatic burst(input int n_ld, input int n_st, input logic [15:0] la, input logic [15:0] sa);
    int guard = 0;
    bit lh, sh;
    ld_req_valid = n_ld > 0; ld_addr = la; ld_tag = 3'd6;
    st_req_valid = n_st > 0; st_addr = sa; st_data = 16'($urandom);
    while ((n_ld > 0 || n_st > 0) && guard < 100) begin
      @(negedge clk);
      lh = ld_req_ready; sh = st_req_ready;
      tick();
      guard++;
      if (lh) n_ld--;
      if (sh) begin
        n_st--;
        st_addr = st_addr + 16'd2;
        st_data = 16'($urandom);
      end
      ld_req_valid = n_ld > 0;
      st_req_valid = n_st > 0;
    end
    check("burst_timeout", guard < 100, 1);
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return 16'h00FF;
      1: return 16'h0100 + 16'($urandom_range(0, 255));
      2: return 16'h00FE;
      default: return 16'($urandom_range(0, 254));
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [TAG_W-1:0] tg;
    logic e;
    logic [6:0] g;
    int nbad;
    bit lh, sh;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none
    repeat (3) tick();
    rst_n = 1;
    ld_req_valid = 1; ld_addr = 16'd100; ld_tag = 3'd5;
    @(negedge clk);
    check("first_handshake_ready", ld_req_ready, 1);
    tick();
    ld_req_valid = 0;
    get_ld(d, tg, e);
    check("single_ld_data", d, 16'h9C40);
    check("single_ld_tag", tg, 3'd5);
    check("single_ld_err", e, 0);

    do_st(16'd120, 16'h1234);
    get_st(e);
    check("st_err", e, 0);
    do_ld(16'd120, 3'd2);
    get_ld(d, tg, e);
    check("st_then_ld_data", d, 16'h1234);
    check("st_then_ld_tag", tg, 3'd2);

    grants.delete();
    burst(1, 1, 16'd102, 16'd122);
    check("contention_order", {grants.size() == 2, grants[0], grants[1]}, 3'b101);
    get_ld(d, tg, e);
    check("contention_ld_data", d, 16'h7530);
    repeat (2) tick();

    grants.delete();
    burst(1, 6, 16'd102, 16'd140);
    g = '0;
    for (int i = 0; i < grants.size() && i < 7; i++) g = {g[5:0], grants[i]};
    check("starve_count", grants.size(), 7);
    check("starve_order", g, 7'b0000100);
    repeat (4) tick();

    do_ld(16'h00FF, 3'd1);
    get_ld(d, tg, e);
    check("err_ld_data", d, 0);
    check("err_ld_err", e, 1);
    do_st(16'h0100, 16'hDEAD);
    get_st(e);
    check("err_st_err", e, 1);

    do_st(16'd100, 16'hBEEF);
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (4) tick();
    check("reset_no_write", {dmem[100], dmem[101]}, 16'h9C40);
    do_ld(16'd100, 3'd3);
    get_ld(d, tg, e);
    check("reset_ld_data", d, 16'h9C40);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      lh = ld_req_valid && ld_req_ready;
      sh = st_req_valid && st_req_ready;
      tick();
      if (lh) ld_req_valid = 0;
      if (sh) st_req_valid = 0;
      if (!ld_req_valid && $urandom_range(0, 2) == 0) begin
        ld_req_valid = 1; ld_addr = rnd_addr(); ld_tag = TAG_W'($urandom);
      end
      if (!st_req_valid && $urandom_range(0, 3) != 0) begin
        st_req_valid = 1; st_addr = rnd_addr(); st_data = 16'($urandom);
      end
    end
    ld_req_valid = 0; st_req_valid = 0;
    repeat (6) tick();
    nbad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) nbad++;
    check("final_mem_image", nbad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
